// File: rtl/juego_pkg.sv
// Shared encodings and helpers for the game sequencer
// and the display path.
package juego_pkg;

    localparam int CLK_HZ = 27_000_000;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        WLCM = 3'd1,
        CH   = 3'd2,
        GAME = 3'd3,
        WL   = 3'd4,
        PA   = 3'd5
    } estado_t;

    typedef enum logic [2:0] {
        M_NONE   = 3'd0,
        M_HOLA   = 3'd1,
        M_ELIJA  = 3'd2,
        M_GANO   = 3'd3,
        M_PERDIO = 3'd4,
        M_PAUSA  = 3'd5
    } msg_t;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd9) begin
            r[3:0] = r[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) begin
                r[7:4] = r[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic msg_t msg_de(input estado_t s, input logic g);
        msg_t m;
        case (s)
            WLCM:    m = M_HOLA;
            CH:      m = M_ELIJA;
            PA:      m = M_PAUSA;
            WL:      m = g ? M_GANO : M_PERDIO;
            default: m = M_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop synchroniser and registered rising-edge detector
// for one debounced board button.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic evento
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            prev   <= 1'b0;
            evento <= 1'b0;
        end else begin
            s1     <= btn;
            s2     <= s1;
            prev   <= s2;
            evento <= s2 & ~prev;
        end
    end

endmodule

// File: rtl/control_juego.sv
// Game sequencer: screen state, hero choice, BCD score,
// win/lose result and menu message select.
module control_juego
    import juego_pkg::*;
#(
    parameter int WLCM_TICKS = 54_000_000,
    parameter int WL_TICKS   = 81_000_000,
    parameter int META       = 99,
    parameter int NUM_HEROES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_power,
    input  logic        btn_start,
    input  logic        btn_pausa,
    input  logic        btn_izq,
    input  logic        btn_der,
    input  logic        colision,
    input  logic        tick_obs,
    output logic [2:0]  presente,
    output logic [2:0]  heroe_sel,
    output logic [11:0] puntaje_bcd,
    output logic        gano,
    output logic        juego_activo,
    output logic [2:0]  menu_msg
);

    localparam int TMAX = (WLCM_TICKS > WL_TICKS) ? WLCM_TICKS : WL_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    estado_t       st;
    estado_t       sig;
    logic [TW-1:0] timer;
    logic [9:0]    cuenta;
    logic          gano_n;
    logic          suma;
    logic          limpia;
    logic          ev_pw, ev_st, ev_pa, ev_iz, ev_de;
    logic [2:0]    hero_mas;
    logic [2:0]    hero_menos;

    detector_flanco u_pw (.clk(clk), .rst_n(rst_n), .btn(btn_power), .evento(ev_pw));
    detector_flanco u_st (.clk(clk), .rst_n(rst_n), .btn(btn_start), .evento(ev_st));
    detector_flanco u_pa (.clk(clk), .rst_n(rst_n), .btn(btn_pausa), .evento(ev_pa));
    detector_flanco u_iz (.clk(clk), .rst_n(rst_n), .btn(btn_izq),   .evento(ev_iz));
    detector_flanco u_de (.clk(clk), .rst_n(rst_n), .btn(btn_der),   .evento(ev_de));

    assign presente   = st;
    assign hero_mas   = (heroe_sel == 3'(NUM_HEROES - 1)) ? 3'd0 : heroe_sel + 3'd1;
    assign hero_menos = (heroe_sel == 3'd0) ? 3'(NUM_HEROES - 1) : heroe_sel - 3'd1;

    always_comb begin
        sig    = st;
        gano_n = gano;
        suma   = 1'b0;
        limpia = 1'b0;
        if (ev_pw) begin
            sig = (st == OFF) ? WLCM : OFF;
        end else begin
            case (st)
                WLCM: if (ev_st || timer == TW'(WLCM_TICKS - 1)) sig = CH;
                CH: if (ev_st) begin
                    sig    = GAME;
                    limpia = 1'b1;
                    gano_n = 1'b0;
                end
                GAME: if (colision) begin
                    sig    = WL;
                    gano_n = 1'b0;
                end else begin
                    suma = tick_obs;
                    // reaching the goal wins in the same edge that stores it
                    if (tick_obs && cuenta == 10'(META - 1)) begin
                        sig    = WL;
                        gano_n = 1'b1;
                    end else if (ev_pa) begin
                        sig = PA;
                    end
                end
                PA: if (ev_pa) sig = GAME;
                WL: begin
                    if (ev_st) sig = CH;
                    else if (timer == TW'(WL_TICKS - 1)) sig = WLCM;
                end
                default: sig = st;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= OFF;
            timer        <= '0;
            cuenta       <= '0;
            puntaje_bcd  <= '0;
            gano         <= 1'b0;
            heroe_sel    <= '0;
            juego_activo <= 1'b0;
            menu_msg     <= 3'd0;
        end else begin
            st           <= sig;
            gano         <= gano_n;
            juego_activo <= (sig == GAME);
            menu_msg     <= msg_de(sig, gano_n);
            if (sig != st)
                timer <= '0;
            else if (st == WLCM || st == WL)
                timer <= timer + 1'b1;
            if (limpia) begin
                cuenta      <= '0;
                puntaje_bcd <= '0;
            end else if (suma) begin
                cuenta      <= cuenta + 10'd1;
                puntaje_bcd <= bcd_inc(puntaje_bcd);
            end
            if (!ev_pw && st == CH && (ev_iz ^ ev_de))
                heroe_sel <= ev_de ? hero_mas : hero_menos;
        end
    end

endmodule

// File: doc/control_juego.md
Name: control_juego

Overview:
Top-level game sequencer that produces the 3-bit screen state consumed by the display driver. It also keeps the hero selection, the BCD score and the win/lose result, and picks which menu message the display shows. It sits between the debounced board buttons, the obstacle/collision logic and the display multiplexer.

Parameters:
WLCM_TICKS, 54_000_000, clk cycles the welcome screen is held (2 s at 27 MHz)
WL_TICKS, 81_000_000, clk cycles the win/lose screen is held (3 s at 27 MHz)
META, 99, binary score that ends the game as a win; legal range 1..999
NUM_HEROES, 4, number of selectable heroes; legal range 2..8

Ports:
clk  in  1  system clock, 27 MHz
rst_n  in  1  reset, asynchronous assert, active-low
btn_power  in  1  debounced level, asynchronous to clk
btn_start  in  1  debounced level, asynchronous to clk
btn_pausa  in  1  debounced level, asynchronous to clk
btn_izq  in  1  debounced level, asynchronous to clk
btn_der  in  1  debounced level, asynchronous to clk
colision  in  1  single-cycle pulse, synchronous to clk, from obstacle logic
tick_obs  in  1  single-cycle pulse, synchronous to clk: one obstacle passed
presente  out  3  screen state: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5
heroe_sel  out  3  selected hero index, 0..NUM_HEROES-1
puntaje_bcd  out  12  score as three BCD digits, [11:8] = hundreds
gano  out  1  1 = last game won, 0 = lost; valid in WL
juego_activo  out  1  high only while presente==GAME; gates obstacle motion
menu_msg  out  3  message select: NONE=0, HOLA=1, ELIJA=2, GANO=3, PERDIO=4, PAUSA=5

Behaviour:
- Reset (rst_n low, asynchronous) drives every output and register to 0: presente=OFF, heroe_sel=0, puntaje=0, gano=0, juego_activo=0, menu_msg=NONE, timer=0, sync flops=0. Reset asserted mid-game aborts to OFF immediately.
- Button path: each button goes through 2 sync flops, then a previous-value flop. A press event is s2 & ~prev. A button that rises before clk edge N causes the state change at edge N+3. Holding a button produces exactly one event.
- colision and tick_obs are used directly; they act on the next clk edge.
- State transitions, in priority order:
  - Any state, power event: go to OFF.
  - OFF, power event: go to WLCM with timer=0.
  - WLCM: timer counts up. When timer==WLCM_TICKS-1, go to CH. A start event skips straight to CH.
  - CH: izq decrements heroe_sel and der increments it, both wrapping modulo NUM_HEROES (0-1 gives NUM_HEROES-1). If izq and der arrive together, no change. A start event goes to GAME and clears the score.
  - GAME: on colision, go to WL with gano=0; colision beats tick_obs and pausa in the same cycle. On tick_obs, the binary score and the BCD score both increment; BCD carries 9 to 0 into the next digit. If the incremented score equals META, go to WL with gano=1 in the same edge that stores the new score. Otherwise a pausa event goes to PA; if tick_obs and pausa arrive together, both are applied.
  - PA: the score is frozen and tick_obs and colision are ignored. A pausa event returns to GAME.
  - WL: timer counts up. When timer==WL_TICKS-1, go to WLCM with timer=0. A start event goes to CH. Score and gano hold until the next GAME entry.
- The timer clears on every state change and only counts in WLCM and WL.
- menu_msg is registered from the next state, so it changes on the same edge as presente: OFF→NONE, WLCM→HOLA, CH→ELIJA, GAME→NONE, PA→PAUSA, WL→GANO if gano else PERDIO.
- juego_activo is registered with the same timing as presente.
- heroe_sel keeps its value across games and power cycles; only reset clears it.
- The score saturates at META and never passes 999.

Decomposition:
- Shared package juego_pkg holds:
  - the presente encodings (OFF..PA);
  - the menu_msg encodings;
  - the 27 MHz clock constant, also used by the display driver's scan divisor.
- One sub-module, detector_flanco: 2-flop synchroniser plus rising-edge detector with asynchronous active-low reset, instantiated five times.
- The FSM, timer and BCD counter stay in control_juego.

Test Plan (WLCM_TICKS=10, WL_TICKS=20, META=3, NUM_HEROES=4):
- Power-up: release rst_n, press btn_power → presente=1 and menu_msg=1 three cycles later; presente=2 and menu_msg=2 exactly 10 cycles after that.
- Hero wrap: in CH, press izq once → heroe_sel=3; press der twice → heroe_sel=1; press izq and der together → heroe_sel stays 1.
- Win: start, then 3 tick_obs pulses → puntaje_bcd=0x003, presente=4, gano=1, menu_msg=3, juego_activo=0 on the third pulse's edge; after 20 cycles presente=1.
- Collision priority: score 1, then colision and tick_obs in the same cycle → presente=4, gano=0, puntaje_bcd stays 0x001, menu_msg=4.
- Pause: in GAME press pausa → presente=5; 5 tick_obs pulses and 1 colision → no change; press pausa → presente=3 with the score unchanged.
- Abort paths: btn_power in GAME → presente=0 and menu_msg=0. rst_n pulled low mid-WL → all outputs 0 asynchronously, before the next clk edge.
- BCD carry (META=150): 109 ticks → 0x109; 1 more tick → 0x110.
